// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 1280x1024@60 timing constants, counter/line widths and request FSM encoding.
package vga_timing_pkg;
   localparam int H_ACTIVE   = 1280;
   localparam int H_FP       = 48;
   localparam int H_SYNC     = 112;
   localparam int H_BP       = 248;
   localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_ACTIVE   = 1024;
   localparam int V_FP       = 1;
   localparam int V_SYNC     = 3;
   localparam int V_BP       = 38;
   localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int PREFETCH_H = 1280;
   localparam int REQ_HOLD   = 4;
   localparam int CNT_W      = 11;
   localparam int LINE_W     = 13;
   typedef enum logic {REQ_IDLE = 1'b0, REQ_HOLD_ST = 1'b1} req_state_e;
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: h/v raster counters with stage-0 sync, active and frame-latch decode.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int HACT = H_ACTIVE,
   parameter int HFP  = H_FP,
   parameter int HSW  = H_SYNC,
   parameter int HBP  = H_BP,
   parameter int VACT = V_ACTIVE,
   parameter int VFP  = V_FP,
   parameter int VSW  = V_SYNC,
   parameter int VBP  = V_BP
) (
   input  logic             clock,
   input  logic             iRST,
   output logic [CNT_W-1:0] h_o,
   output logic [CNT_W-1:0] v_o,
   output logic             active_o,
   output logic             hs_o,
   output logic             vs_o,
   output logic             frame_latch_o
);
   localparam int HT = HACT + HFP + HSW + HBP;
   localparam int VT = VACT + VFP + VSW + VBP;
   logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
   always_comb begin
      h_d = (h_q == CNT_W'(HT - 1)) ? '0 : h_q + 1'b1;
      v_d = (h_q != CNT_W'(HT - 1)) ? v_q : (v_q == CNT_W'(VT - 1)) ? '0 : v_q + 1'b1;
   end
   always_ff @(posedge clock or posedge iRST)
      if (iRST) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   assign h_o           = h_q;
   assign v_o           = v_q;
   assign active_o      = (h_q < CNT_W'(HACT)) && (v_q < CNT_W'(VACT));
   assign hs_o          = (h_q >= CNT_W'(HACT + HFP)) && (h_q < CNT_W'(HACT + HFP + HSW));
   assign vs_o          = (v_q >= CNT_W'(VACT + VFP)) && (v_q < CNT_W'(VACT + VFP + VSW));
   assign frame_latch_o = (v_q == CNT_W'(VT - 1)) && (h_q == '0);
endmodule

// File: rtl/vga_fifo_to_pixel.sv
// vga_fifo_to_pixel: pops the VGA line FIFO per active pixel, drives grey RGB/sync/blank, requests lines.
// Optional grey h^v test pattern when VGA_TEST_PATTERN_EN is defined.
module vga_fifo_to_pixel
   import vga_timing_pkg::*;
#(
   parameter int HACT = H_ACTIVE,
   parameter int HFP  = H_FP,
   parameter int HSW  = H_SYNC,
   parameter int HBP  = H_BP,
   parameter int VACT = V_ACTIVE,
   parameter int VFP  = V_FP,
   parameter int VSW  = V_SYNC,
   parameter int VBP  = V_BP,
   parameter int PREF = PREFETCH_H,
   parameter int HOLD = REQ_HOLD
) (
   input  logic              clock,
   input  logic              iRST,
   output logic [LINE_W-1:0] oVGA_LINE_TO_LOAD,
   output logic              oVGA_LOAD_TO_FIFO_REQ,
   output logic              oFRAME_LATCH,
   output logic              oFIFO_RDREQ,
   input  logic              iFIFO_EMPTY,
   input  logic [7:0]        iFIFO_Q,
`ifdef VGA_TEST_PATTERN_EN
   input  logic              iTEST_PATTERN,
`endif
   output logic [7:0]        oVGA_R,
   output logic [7:0]        oVGA_G,
   output logic [7:0]        oVGA_B,
   output logic              oVGA_HS,
   output logic              oVGA_VS,
   output logic              oVGA_BLANK_N,
   output logic              oUNDERFLOW,
   input  logic              iCLR_STATUS
);
   localparam int VT = VACT + VFP + VSW + VBP;
   localparam int HW = $clog2(HOLD + 1);
   logic [CNT_W-1:0]  h, v;
   logic              act0, hs0, vs0, tp0, rdreq, trig;
   logic              taken_q, hs1_q, vs1_q, act1_q, hs2_q, vs2_q, blank_q, und_q, und_d;
   logic [7:0]        pix_q, pix_d;
   req_state_e        state_q, state_d;
   logic [HW-1:0]     cnt_q, cnt_d;
   logic [LINE_W-1:0] line_q, line_d;

   vga_timing_gen #(
      .HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP),
      .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP)
   ) u_timing (
      .clock(clock), .iRST(iRST), .h_o(h), .v_o(v), .active_o(act0),
      .hs_o(hs0), .vs_o(vs0), .frame_latch_o(oFRAME_LATCH)
   );

   // Reset leaves the counters at an active pixel, so the pop must be masked explicitly.
   assign rdreq = !iRST && act0 && !iFIFO_EMPTY && !tp0;
   assign und_d = (act0 && iFIFO_EMPTY && !tp0) || (und_q && !iCLR_STATUS);

`ifdef VGA_TEST_PATTERN_EN
   logic       tp1_q;
   logic [7:0] pat1_q;
   always_ff @(posedge clock or posedge iRST)
      if (iRST) begin
         tp1_q  <= 1'b0;
         pat1_q <= '0;
      end else begin
         tp1_q  <= iTEST_PATTERN;
         pat1_q <= act0 ? (h[7:0] ^ v[7:0]) : 8'h00;
      end
   assign tp0   = iTEST_PATTERN;
   assign pix_d = tp1_q ? pat1_q : taken_q ? iFIFO_Q : 8'h00;
`else
   assign tp0   = 1'b0;
   assign pix_d = taken_q ? iFIFO_Q : 8'h00;
`endif

   always_ff @(posedge clock or posedge iRST)
      if (iRST) begin
         taken_q <= 1'b0;
         hs1_q   <= 1'b0;
         vs1_q   <= 1'b0;
         act1_q  <= 1'b0;
         pix_q   <= '0;
         hs2_q   <= 1'b0;
         vs2_q   <= 1'b0;
         blank_q <= 1'b0;
         und_q   <= 1'b0;
         state_q <= REQ_IDLE;
         cnt_q   <= '0;
         line_q  <= '0;
      end else begin
         taken_q <= rdreq;
         hs1_q   <= hs0;
         vs1_q   <= vs0;
         act1_q  <= act0;
         pix_q   <= pix_d;
         hs2_q   <= hs1_q;
         vs2_q   <= vs1_q;
         blank_q <= act1_q;
         und_q   <= und_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
      end

   // Request the line after the current one; the last blanking line fetches line 0 of the next frame.
   assign trig = (state_q == REQ_IDLE) && (h == CNT_W'(PREF)) &&
                 ((v < CNT_W'(VACT - 1)) || (v == CNT_W'(VT - 1)));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      if (trig) begin
         state_d = REQ_HOLD_ST;
         cnt_d   = HW'(HOLD - 1);
         line_d  = (v == CNT_W'(VT - 1)) ? '0 : LINE_W'(v) + 1'b1;
      end else if (state_q == REQ_HOLD_ST) begin
         cnt_d   = cnt_q - 1'b1;
         state_d = (cnt_q == '0) ? REQ_IDLE : REQ_HOLD_ST;
      end
   end

   assign oFIFO_RDREQ           = rdreq;
   assign oVGA_LINE_TO_LOAD     = line_q;
   assign oVGA_LOAD_TO_FIFO_REQ = (state_q == REQ_HOLD_ST);
   assign oVGA_R                = pix_q;
   assign oVGA_G                = pix_q;
   assign oVGA_B                = pix_q;
   assign oVGA_HS               = hs2_q;
   assign oVGA_VS               = vs2_q;
   assign oVGA_BLANK_N          = blank_q;
   assign oUNDERFLOW            = und_q;
endmodule

// File: tb/tb_vga_fifo_to_pixel.sv
// tb_vga_fifo_to_pixel: reduced-raster bench with a cycle-level reference model plus timing tables and corner sequences.
module tb_vga_fifo_to_pixel;
   localparam int HA = 16, HF = 2, HS = 3, HB = 4, HT = HA + HF + HS + HB;
   localparam int VA = 8, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
   localparam int PF = 16, RH = 4, FR = HT * VT;

   typedef struct {int v; int h; bit hs; bit vs; bit bl; bit fl;} tvec_t;

   logic        clock = 1'b0, iRST = 1'b1, iFIFO_EMPTY = 1'b0, iCLR_STATUS = 1'b0;
   logic [7:0]  iFIFO_Q = 8'h00, src = 8'h00;
   logic [12:0] oVGA_LINE_TO_LOAD;
   logic        oVGA_LOAD_TO_FIFO_REQ, oFRAME_LATCH, oFIFO_RDREQ;
   logic [7:0]  oVGA_R, oVGA_G, oVGA_B;
   logic        oVGA_HS, oVGA_VS, oVGA_BLANK_N, oUNDERFLOW;
`ifdef VGA_TEST_PATTERN_EN
   logic        iTEST_PATTERN = 1'b0;
`endif

   int checks = 0, failures = 0;
   int mh = 0, mv = 0, age = 1000, mline = 0;
   bit m_und = 0;
   logic [7:0] mpc = 8'h00;
   bit hs_h[2], vs_h[2], act_h[2];
   logic [7:0] pix_h[2];
   tvec_t tbl[15];

   always #5 clock = ~clock;

   vga_fifo_to_pixel #(
      .HACT(HA), .HFP(HF), .HSW(HS), .HBP(HB), .VACT(VA), .VFP(VF), .VSW(VS), .VBP(VB),
      .PREF(PF), .HOLD(RH)
   ) dut (
      .clock(clock), .iRST(iRST), .oVGA_LINE_TO_LOAD(oVGA_LINE_TO_LOAD),
      .oVGA_LOAD_TO_FIFO_REQ(oVGA_LOAD_TO_FIFO_REQ), .oFRAME_LATCH(oFRAME_LATCH),
      .oFIFO_RDREQ(oFIFO_RDREQ), .iFIFO_EMPTY(iFIFO_EMPTY), .iFIFO_Q(iFIFO_Q),
`ifdef VGA_TEST_PATTERN_EN
      .iTEST_PATTERN(iTEST_PATTERN),
`endif
      .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B), .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS),
      .oVGA_BLANK_N(oVGA_BLANK_N), .oUNDERFLOW(oUNDERFLOW), .iCLR_STATUS(iCLR_STATUS)
   );

   // Normal-mode FIFO: data appears the cycle after a pop; contents are an incrementing byte stream.
   always @(posedge clock)
      if (oFIFO_RDREQ) begin
         iFIFO_Q <= src;
         src     <= src + 8'd1;
      end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference model: raster position, pop index and request age derived from cycle count.
   always @(negedge clock) begin
      bit act, hs0, vs0, tp, pop;
      logic [7:0] pix;
      if (iRST) begin
         chk("rst_rdreq", oFIFO_RDREQ, 0);
         chk("rst_req", oVGA_LOAD_TO_FIFO_REQ, 0);
         chk("rst_line", oVGA_LINE_TO_LOAD, 0);
         chk("rst_rgb", {oVGA_R, oVGA_G, oVGA_B}, 0);
         chk("rst_sync", {oVGA_HS, oVGA_VS, oVGA_BLANK_N}, 0);
         chk("rst_fl", oFRAME_LATCH, 0);
         chk("rst_und", oUNDERFLOW, 0);
         mh = 0; mv = 0; age = 1000; mline = 0; m_und = 0;
         for (int i = 0; i < 2; i++) begin
            hs_h[i] = 0; vs_h[i] = 0; act_h[i] = 0; pix_h[i] = 8'h00;
         end
      end else begin
         act = (mh < HA) && (mv < VA);
         hs0 = (mh >= HA + HF) && (mh < HA + HF + HS);
         vs0 = (mv >= VA + VF) && (mv < VA + VF + VS);
`ifdef VGA_TEST_PATTERN_EN
         tp = iTEST_PATTERN;
`else
         tp = 0;
`endif
         pop = act && !iFIFO_EMPTY && !tp;
         pix = tp ? (act ? 8'(mh ^ mv) : 8'h00) : (pop ? mpc : 8'h00);
         chk("rdreq", oFIFO_RDREQ, pop);
         chk("hs", oVGA_HS, hs_h[1]);
         chk("vs", oVGA_VS, vs_h[1]);
         chk("blank_n", oVGA_BLANK_N, act_h[1]);
         chk("rgb", {oVGA_R, oVGA_G, oVGA_B}, {pix_h[1], pix_h[1], pix_h[1]});
         chk("frame_latch", oFRAME_LATCH, (mv == VT - 1) && (mh == 0));
         chk("underflow", oUNDERFLOW, m_und);
         chk("req", oVGA_LOAD_TO_FIFO_REQ, (age >= 1) && (age <= RH));
         chk("line", oVGA_LINE_TO_LOAD, mline);
         m_und = (act && iFIFO_EMPTY && !tp) || (m_und && !iCLR_STATUS);
         if (mh == PF && (mv < VA - 1 || mv == VT - 1) && age > RH) begin
            age = 1;
            mline = (mv == VT - 1) ? 0 : mv + 1;
         end else age++;
         if (pop) mpc++;
         hs_h[1] = hs_h[0]; vs_h[1] = vs_h[0]; act_h[1] = act_h[0]; pix_h[1] = pix_h[0];
         hs_h[0] = hs0; vs_h[0] = vs0; act_h[0] = act; pix_h[0] = pix;
         mh++;
         if (mh == HT) begin
            mh = 0;
            mv = (mv + 1) % VT;
         end
      end
   end

   task automatic wait_pos(input int v, input int h);
      int n = 0;
      @(posedge clock);
      while (!(mv == v && mh == h) && n < 2 * FR) begin
         @(posedge clock);
         n++;
      end
      chk("wait_pos_v", mv, v);
      chk("wait_pos_h", mh, h);
   endtask

   task automatic req_frame(output int rises, output int rd);
      bit prev = 0;
      int run = 0;
      rises = 0; rd = 0;
      wait_pos(VT - 1, 0);
      #2 chk("fl_pulse", oFRAME_LATCH, 1);
      for (int i = 0; i < FR; i++) begin
         @(posedge clock);
         #2;
         if (oFIFO_RDREQ) rd++;
         if (oVGA_LOAD_TO_FIFO_REQ && !prev) begin
            chk("req_line_order", oVGA_LINE_TO_LOAD, rises);
            if (rises == 0) begin
               chk("req0_v", mv, VT - 1);
               chk("req0_h", mh, PF + 1);
            end
            rises++;
         end
         if (oVGA_LOAD_TO_FIFO_REQ) run++;
         else begin
            if (prev) chk("req_len", run, RH);
            run = 0;
         end
         prev = oVGA_LOAD_TO_FIFO_REQ;
      end
      chk("req_count", rises, VA);
   endtask

   initial begin
      #(FR * 10 * 60);
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int rises, rd, t0, t1, bl, n;
      bit prevhs;
      tbl = '{'{0, 0, 0, 0, 1, 0}, '{0, 15, 0, 0, 1, 0}, '{0, 18, 1, 0, 0, 0}, '{0, 21, 0, 0, 0, 0},
              '{1, 16, 0, 0, 0, 0}, '{1, 20, 1, 0, 0, 0}, '{7, 15, 0, 0, 1, 0}, '{7, 17, 0, 0, 0, 0},
              '{8, 0, 0, 0, 0, 0},  '{9, 0, 0, 1, 0, 0},  '{10, 24, 0, 1, 0, 0}, '{11, 0, 0, 0, 0, 0},
              '{12, 0, 0, 0, 0, 1}, '{12, 19, 1, 0, 0, 0}, '{0, 3, 0, 0, 1, 0}};
      repeat (3) @(posedge clock);
      #1 iRST = 1'b0;

      for (int i = 0; i < 15; i++) begin
         wait_pos(tbl[i].v, tbl[i].h);
         #2 chk("tbl_fl", oFRAME_LATCH, tbl[i].fl);
         @(posedge clock);
         @(posedge clock);
         #2;
         chk("tbl_hs", oVGA_HS, tbl[i].hs);
         chk("tbl_vs", oVGA_VS, tbl[i].vs);
         chk("tbl_blank_n", oVGA_BLANK_N, tbl[i].bl);
      end

      wait_pos(1, 0);
      t0 = -1; t1 = -1; bl = 0; prevhs = oVGA_HS;
      for (int i = 0; i < 2 * HT + 2; i++) begin
         @(posedge clock);
         #2;
         if (oVGA_HS && !prevhs) begin
            if (t0 < 0) t0 = i;
            else if (t1 < 0) t1 = i;
         end
         prevhs = oVGA_HS;
         if (i < HT && !oVGA_BLANK_N) bl++;
      end
      chk("hs_period", t1 - t0, HT);
      chk("blank_low_per_line", bl, HT - HA);

      req_frame(rises, rd);

      wait_pos(2, 5);
      #1 iFIFO_EMPTY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2 chk("uf_no_pop", oFIFO_RDREQ, 0);
         @(posedge clock);
      end
      #1 iFIFO_EMPTY = 1'b0;
      #2 chk("uf_set", oUNDERFLOW, 1);
      wait_pos(4, 0);
      #2 chk("uf_sticky", oUNDERFLOW, 1);
      wait_pos(4, HA + 1);
      #1 iCLR_STATUS = 1'b1;
      @(posedge clock);
      #1 iCLR_STATUS = 1'b0;
      #1 chk("uf_clear", oUNDERFLOW, 0);

      wait_pos(5, 3);
      #1 begin iFIFO_EMPTY = 1'b1; iCLR_STATUS = 1'b1; end
      @(posedge clock);
      #1 begin iFIFO_EMPTY = 1'b0; iCLR_STATUS = 1'b0; end
      #1 chk("uf_set_wins", oUNDERFLOW, 1);
      wait_pos(5, HA + 2);
      #1 iCLR_STATUS = 1'b1;
      @(posedge clock);
      #1 iCLR_STATUS = 1'b0;
      #1 chk("uf_clear2", oUNDERFLOW, 0);

      for (int i = 0; i < 3 * FR; i++) begin
         @(posedge clock);
         #1;
         iFIFO_EMPTY = ($urandom_range(0, 15) == 0);
         iCLR_STATUS = ($urandom_range(0, 39) == 0);
      end
      @(posedge clock);
      #1 begin iFIFO_EMPTY = 1'b0; iCLR_STATUS = 1'b1; end
      @(posedge clock);
      #1 iCLR_STATUS = 1'b0;

      wait_pos(5, PF + 2);
      #1 iRST = 1'b1;
      #2 chk("rst_mid_req_drop", oVGA_LOAD_TO_FIFO_REQ, 0);
      chk("rst_mid_blank", oVGA_BLANK_N, 0);
      repeat (2) @(posedge clock);
      #1 iRST = 1'b0;
      n = 0;
      @(posedge clock);
      #2;
      while (!oVGA_LOAD_TO_FIFO_REQ && n < 2 * FR) begin
         @(posedge clock);
         #2;
         n++;
      end
      chk("rst_first_req_line", oVGA_LINE_TO_LOAD, 1);
      chk("rst_first_req_v", mv, 0);
      chk("rst_first_req_h", mh, PF + 1);

`ifdef VGA_TEST_PATTERN_EN
      wait_pos(0, 0);
      #1 iTEST_PATTERN = 1'b1;
      wait_pos(3, 5);
      @(posedge clock);
      @(posedge clock);
      #2 chk("tp_pixel_3_5", oVGA_R, 8'h06);
      req_frame(rises, rd);
      chk("tp_no_rdreq", rd, 0);
      @(posedge clock);
      #1 iTEST_PATTERN = 1'b0;
      repeat (FR) @(posedge clock);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
